// File: rtl/mcu_seq_ctrl.sv
// Multicycle instruction sequencer: owns PC, IR and flags, fetches through a
// ready-handshake memory port and steers the register file, ALU and write-back.
`timescale 1ns/1ps
module mcu_seq_ctrl #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  input  logic [N-1:0] dp_addr,
  input  logic         z_in,
  input  logic         n_in,
  input  logic         o_in,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] rd_addr,
  output logic [M-1:0] ra_addr,
  output logic [M-1:0] rb_addr,
  output logic [2:0]   alu_op,
  output logic         rf_we,
  output logic [1:0]   wb_sel,
  output logic [N-1:0] imm,
  output logic         flag_en,
  output logic         halted
);

  localparam int unsigned OFF_W = N - 4;
  localparam int unsigned IMM_W = N - 4 - M;
  localparam int unsigned RD_HI = N - 5;
  localparam int unsigned RA_HI = N - 5 - M;
  localparam int unsigned RB_HI = N - 5 - 2 * M;

  localparam logic [3:0] OP_NOP  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_BRN  = 4'hC;
  localparam logic [3:0] OP_BRO  = 4'hD;
  localparam logic [3:0] OP_BRA  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_ir;
  logic         r_z;
  logic         r_n;
  logic         r_o;

  logic [3:0]   w_op;
  logic [N-1:0] w_imm;
  logic [N-1:0] w_off;
  logic         w_is_alu;
  logic         w_is_mem;
  logic         w_br_take;

  assign w_op     = r_ir[N-1 -: 4];
  assign w_imm    = {{(N-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
  assign w_off    = {{4{r_ir[OFF_W-1]}}, r_ir[OFF_W-1:0]};
  assign w_is_alu = !w_op[3] && (w_op != OP_NOP);
  assign w_is_mem = (w_op == OP_LD) || (w_op == OP_ST);

  // Branch condition evaluated on the flags latched by earlier ALU ops
  always_comb begin
    w_br_take = 1'b0;
    case (w_op)
      OP_BRZ:  w_br_take = r_z;
      OP_BRN:  w_br_take = r_n;
      OP_BRO:  w_br_take = r_o;
      OP_BRA:  w_br_take = 1'b1;
      default: w_br_take = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic; memory phases wait for mem_ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_mem)              w_next = S_MEM;
        else if (w_op == OP_HALT)  w_next = S_HALT;
        else                       w_next = S_FETCH;
      end
      S_MEM:    if (mem_ready) w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode; everything forced low while reset is held
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    rd_addr  = '0;
    ra_addr  = '0;
    rb_addr  = '0;
    alu_op   = 3'd0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    imm      = '0;
    flag_en  = 1'b0;
    halted   = 1'b0;
    if (rst) begin
      rd_addr = r_ir[RD_HI -: M];
      ra_addr = r_ir[RA_HI -: M];
      rb_addr = r_ir[RB_HI -: M];
      alu_op  = w_op[2:0];
      imm     = w_imm;
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = r_pc;
        end
        S_EXEC: begin
          if (w_is_alu) begin
            rf_we   = 1'b1;
            flag_en = 1'b1;
          end else if (w_op == OP_LDI) begin
            rf_we  = 1'b1;
            wb_sel = 2'd1;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (w_op == OP_ST);
          mem_addr = dp_addr;
          if (mem_ready && (w_op == OP_LD)) begin
            rf_we  = 1'b1;
            wb_sel = 2'd2;
          end
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  // PC, IR and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
      r_ir <= '0;
      r_z  <= 1'b0;
      r_n  <= 1'b0;
      r_o  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + N'(1);
          end
        end
        S_EXEC: begin
          if (w_is_alu) begin
            r_z <= z_in;
            r_n <= n_in;
            r_o <= o_in;
          end
          if (w_br_take) r_pc <= r_pc + w_off;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_seq_ctrl.sv
// Self-checking bench for mcu_seq_ctrl: directed vector table, hand-written
// halt/reset sequences and random instruction streams against an
// instruction-level model of PC, flags and per-cycle port activity.
`timescale 1ns/1ps
module tb_mcu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] dp_addr;
  logic        z_in, n_in, o_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  rd_addr, ra_addr, rb_addr;
  logic [2:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [15:0] imm;
  logic        flag_en;
  logic        halted;

  mcu_seq_ctrl #(.N(16), .M(3)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dp_addr(dp_addr), .z_in(z_in), .n_in(n_in), .o_in(o_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .rd_addr(rd_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .imm(imm),
    .flag_en(flag_en), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  aop;
    logic        rf_we;
    logic [1:0]  wb;
    logic [15:0] imm;
    logic        fen;
    logic        halt;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    int          fw;
    int          mw;
    logic        z, n, o;
    logic [15:0] dp;
    int          exp_lat;
    logic [15:0] exp_addr;
    logic        exp_req;
  } vec_t;

  outs_t got;
  assign got = {mem_req, mem_we, mem_addr, rd_addr, ra_addr, rb_addr, alu_op,
                rf_we, wb_sel, imm, flag_en, halted};

  int n_chk  = 0;
  int n_fail = 0;

  // Architectural model state
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic        m_z, m_n, m_o, m_halt;

  function automatic outs_t base(input logic [15:0] ir);
    outs_t e;
    e      = '0;
    e.rd   = ir[11:9];
    e.ra   = ir[8:6];
    e.rb   = ir[5:3];
    e.aop  = ir[14:12];
    e.imm  = {{7{ir[8]}}, ir[8:0]};
    e.halt = m_halt;
    return e;
  endfunction

  task automatic chk(input string nm, input outs_t e, input bit strict);
    outs_t g;
    g = got;
    if (!strict && !e.req) g.addr = e.addr;
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%h want=%h", nm, $time, g, e);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int w);
    n_chk++;
    if (g != w) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0d want=%0d", nm, $time, g, w);
    end
  endtask

  task automatic rand_side();
    z_in      = 1'($urandom);
    n_in      = 1'($urandom);
    o_in      = 1'($urandom);
    dp_addr   = 16'($urandom);
    mem_rdata = 16'($urandom);
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_z = 0; m_n = 0; m_o = 0; m_halt = 0;
  endtask

  // Fetch, decode and execute one instruction, checking every cycle
  task automatic run_front(input logic [15:0] instr, input int fw,
                           input logic z, input logic n, input logic o,
                           inout int lat);
    outs_t e;
    logic [3:0] op;
    bit take;
    for (int w = 0; w <= fw; w++) begin
      rand_side();
      mem_ready = (w == fw);
      if (w == fw) mem_rdata = instr;
      e = base(m_ir); e.req = 1'b1; e.addr = m_pc;
      #1 chk("fetch", e, 0);
      lat++;
      @(negedge clk);
    end
    m_ir = instr;
    m_pc = m_pc + 16'd1;
    op   = instr[15:12];
    rand_side();
    mem_ready = 1'($urandom);
    e = base(m_ir);
    #1 chk("decode", e, 0);
    lat++;
    @(negedge clk);
    rand_side();
    mem_ready = 1'($urandom);
    z_in = z; n_in = n; o_in = o;
    e = base(m_ir);
    if (op <= 4'd6) begin e.rf_we = 1; e.fen = 1; end
    else if (op == 4'h8) begin e.rf_we = 1; e.wb = 2'd1; end
    #1 chk("exec", e, 0);
    lat++;
    @(negedge clk);
    take = (op == 4'hB && m_z) || (op == 4'hC && m_n) ||
           (op == 4'hD && m_o) || (op == 4'hE);
    if (take) m_pc = m_pc + {{4{instr[11]}}, instr[11:0]};
    if (op <= 4'd6) begin m_z = z; m_n = n; m_o = o; end
    if (op == 4'hF) m_halt = 1'b1;
  endtask

  task automatic run_mem(input int mw, input logic [15:0] dp, inout int lat);
    outs_t e;
    logic [3:0] op;
    op = m_ir[15:12];
    for (int w = 0; w <= mw; w++) begin
      rand_side();
      dp_addr   = dp;
      mem_ready = (w == mw);
      e = base(m_ir); e.req = 1; e.we = (op == 4'hA); e.addr = dp;
      if (op == 4'h9 && w == mw) begin e.rf_we = 1; e.wb = 2'd2; end
      #1 chk("mem", e, 0);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                           input logic z, input logic n, input logic o,
                           input logic [15:0] dp, output int lat);
    lat = 0;
    run_front(instr, fw, z, n, o, lat);
    if (instr[15:12] == 4'h9 || instr[15:12] == 4'hA) run_mem(mw, dp, lat);
  endtask

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    outs_t e;
    logic [15:0] ri;

    vecs[0]  = '{16'h83FD, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h0001, 1'b1};
    vecs[1]  = '{16'h8405, 3, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 6, 16'h0002, 1'b1};
    vecs[2]  = '{16'h7000, 0, 0, 1'b1, 1'b1, 1'b1, 16'h0000, 3, 16'h0003, 1'b1};
    vecs[3]  = '{16'h4000, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h0004, 1'b1};
    vecs[4]  = '{16'h0650, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 16'h0005, 1'b1};
    vecs[5]  = '{16'hBFFE, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h0004, 1'b1};
    vecs[6]  = '{16'h0650, 0, 0, 1'b0, 1'b1, 1'b0, 16'h0000, 3, 16'h0005, 1'b1};
    vecs[7]  = '{16'hBFFE, 1, 0, 1'b1, 1'b1, 1'b1, 16'h0000, 4, 16'h0006, 1'b1};
    vecs[8]  = '{16'h94C0, 0, 2, 1'b1, 1'b1, 1'b1, 16'h0040, 6, 16'h0007, 1'b1};
    vecs[9]  = '{16'hA0E0, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0040, 5, 16'h0008, 1'b1};
    vecs[10] = '{16'hC003, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h000C, 1'b1};
    vecs[11] = '{16'hD005, 0, 0, 1'b1, 1'b1, 1'b1, 16'h0000, 3, 16'h000D, 1'b1};
    vecs[12] = '{16'hEFF2, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h0000, 1'b1};
    vecs[13] = '{16'hEFFE, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'hFFFF, 1'b1};
    vecs[14] = '{16'hF000, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 16'h0000, 1'b0};

    rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0; dp_addr = '0;
    z_in = 0; n_in = 0; o_in = 0;
    model_reset();
    #2 chk("reset_state", outs_t'('0), 1);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, vecs[i].fw, vecs[i].mw, vecs[i].z, vecs[i].n,
                vecs[i].o, vecs[i].dp, lat);
      mem_ready = 1'b0;
      #1;
      chk_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk_int($sformatf("vec%0d_next", i),
              int'({mem_req, (mem_req ? mem_addr : 16'h0), halted}),
              int'({vecs[i].exp_req, vecs[i].exp_addr, !vecs[i].exp_req}));
      @(negedge clk);
      if (!vecs[i].exp_req) break;
    end

    // Halted for 20 cycles regardless of mem_ready
    for (int c = 0; c < 20; c++) begin
      rand_side();
      mem_ready = 1'($urandom);
      e = base(m_ir); e.halt = 1'b1;
      #1 chk("halt_hold", e, 0);
      @(negedge clk);
    end

    // Reset out of HALT, then fetch resumes at 0
    #2 rst = 1'b0;
    #1 chk("reset_from_halt", outs_t'('0), 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Random instruction stream (no HALT)
    for (int k = 0; k < 60; k++) begin
      ri = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ri, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), lat);
    end

    // Reset asserted during a LD wait state
    lat = 0;
    run_front(16'h94C0, 0, 1'b0, 1'b0, 1'b0, lat);
    rand_side();
    dp_addr = 16'h0040; mem_ready = 1'b0;
    e = base(m_ir); e.req = 1'b1; e.addr = 16'h0040;
    #1 chk("ld_wait", e, 0);
    @(negedge clk);
    dp_addr = 16'h0040; mem_ready = 1'b1;
    #2 rst = 1'b0;
    #1 chk("reset_mid_mem", outs_t'('0), 1);
    @(negedge clk);
    #1 chk("reset_held", outs_t'('0), 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_instr(16'h83FD, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0, lat);
    mem_ready = 1'b0;
    #1;
    chk_int("post_reset_latency", lat, 3);
    chk_int("post_reset_next", int'(mem_addr), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
